wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register: selects the writeback value and commits it to a 32-entry general-purpose register file.
- Provides two read ports to the decode stage. Retires one instruction per valid writeback and counts retired writes.
- Sits between the MEM/WB register outputs and the ID stage. It closes the pipeline loop.

Parameters:
- N, 32, data width of registers and writeback values
- SP_INIT, 32'h7FFF_EFFC, reset value of register 29 ($sp)
- GP_INIT, 32'h1000_8000, reset value of register 28 ($gp)

Ports:
- clk  input  1  pipeline clock; register file writes on posedge
- reset  input  1  async active-low reset
- ALU_result  input  N  from MEM/WB ALU_result_out
- Read_data  input  N  from MEM/WB Read_data_out
- PC_4  input  N  from MEM/WB PC_4_out
- WriteRegister  input  5  from MEM/WB WriteRegister_out
- MemtoReg  input  1  from MEM/WB; 1 selects Read_data
- RegWrite  input  1  from MEM/WB; write enable
- JalLink  input  1  1 selects PC_4 (link write); has priority over MemtoReg
- ReadReg1  input  5  ID read address A
- ReadReg2  input  5  ID read address B
- ReadData1  output  N  register A contents
- ReadData2  output  N  register B contents
- WB_data  output  N  selected writeback value (combinational, for forwarding unit)
- RetireCount  output  32  number of committed register writes

Behaviour:
- Reset is asynchronous and active-low. While reset=0, every register clears to 0 except reg 28=GP_INIT and reg 29=SP_INIT. RetireCount clears to 0.
- Output values during and after reset: ReadData1/2 follow the reset contents. WB_data follows the inputs, which are 0 from MEM/WB in reset.
- Writeback select is priority ordered: JalLink → PC_4; else MemtoReg → Read_data; else ALU_result. It is purely combinational.
- Write timing: MEM/WB updates on negedge clk. The regfile commits WB_data on the following posedge when RegWrite=1 and WriteRegister≠0. Latency from MEM/WB capture to architectural update is half a cycle.
- Register 0 is hardwired to 0. Writes to it are discarded, and reads of it return 0 regardless of bypass.
- Reads are combinational from storage.
- RetireCount increments by 1 on each posedge that performs a committed write (RegWrite=1, WriteRegister≠0). It wraps from 32'hFFFF_FFFF to 0 with no flag.
- When RegWrite=0, contents and RetireCount hold.
- If reset asserts mid-cycle, the clear wins immediately. The first posedge after reset deasserts commits normally.
- Both read ports may address the same register. They return identical data.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address equals WriteRegister, with RegWrite=1 and address≠0, returns WB_data combinationally (write-before-read within the same cycle). No half-cycle dependence is needed by ID.
- Undefined: reads return stored contents only. The new value is visible after the commit posedge.

Decomposition:
- Shared package holds:
  - REG_ZERO=5'd0, REG_GP=5'd28, REG_SP=5'd29, REG_RA=5'd31
  - the writeback-select encoding, as an enum {WB_ALU, WB_MEM, WB_LINK}
  - default SP/GP init constants
- One sub-module is natural: wb_mux. It takes the three candidate values plus JalLink/MemtoReg and produces WB_data.
- Storage, bypass and counter stay in wb_regfile.

Test Plan:
- Reset check: pulse reset=0 mid-cycle → all reads 0 except ReadReg1=29 → 32'h7FFF_EFFC and ReadReg2=28 → 32'h1000_8000. RetireCount=0.
- ALU write: ALU_result=32'hDEAD_BEEF, WriteRegister=8, RegWrite=1, MemtoReg=0 → after posedge ReadReg1=8 gives 32'hDEAD_BEEF and RetireCount=1.
- Load and link: MemtoReg=1, Read_data=32'h0000_1234, reg 9 → 32'h1234. Then JalLink=1, MemtoReg=1, PC_4=32'h0040_0008, reg 31 → 32'h0040_0008, proving JalLink priority.
- $zero: RegWrite=1, WriteRegister=0, ALU_result=32'hFFFF_FFFF → reg 0 reads 0, RetireCount unchanged, no bypass to reg 0.
- Bypass: reg 10 holds 5. Drive write of 7 to reg 10 with ReadReg2=10 before the posedge → with REGFILE_BYPASS_EN ReadData2=7 immediately; without it ReadData2=5 until the posedge, then 7.
- Counter wrap: force RetireCount to 32'hFFFF_FFFF, commit one write → 0. A cycle with RegWrite=0 → holds.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared constants and writeback-select encoding for wb_regfile
//
// Purpose : Architectural register numbers, default $sp/$gp reset values and
//           the writeback-source encoding used by wb_mux and wb_regfile.
// Ports   : none (package)
package wb_regfile_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [31:0] DEFAULT_SP_INIT = 32'h7FFF_EFFC;
  localparam logic [31:0] DEFAULT_GP_INIT = 32'h1000_8000;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  // Link writes outrank loads, which outrank ALU results.
  function automatic wb_sel_e wb_select(input logic jal_link, input logic mem_to_reg);
    if (jal_link)        return WB_LINK;
    else if (mem_to_reg) return WB_MEM;
    else                 return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// rtl/wb_regfile_wb_mux.sv - combinational writeback value select
//
// Purpose : Chooses the value committed to the register file from the three
//           MEM/WB candidates.
// Ports   : i_alu_result  N  ALU result
//           i_read_data   N  load data
//           i_pc_4        N  return address for link writes
//           i_jal_link    1  selects i_pc_4 (highest priority)
//           i_mem_to_reg  1  selects i_read_data
//           o_wb_data     N  selected writeback value
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_alu_result,
  input  logic [N-1:0] i_read_data,
  input  logic [N-1:0] i_pc_4,
  input  logic         i_jal_link,
  input  logic         i_mem_to_reg,
  output logic [N-1:0] o_wb_data
);

  wb_sel_e w_sel;

  always_comb begin
    w_sel     = wb_select(i_jal_link, i_mem_to_reg);
    o_wb_data = i_alu_result;
    case (w_sel)
      WB_LINK: o_wb_data = i_pc_4;
      WB_MEM:  o_wb_data = i_read_data;
      default: o_wb_data = i_alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage and 32-entry general-purpose register file
//
// Purpose : Selects the writeback value from MEM/WB, commits it on posedge clk,
//           serves two combinational read ports to ID and counts retired writes.
// Option  : REGFILE_BYPASS_EN - when defined, a read of the register being
//           written this cycle returns WB_data combinationally.
// Ports   : clk            1  register file writes on posedge
//           reset          1  asynchronous, active-low
//           ALU_result     N  writeback candidate (default)
//           Read_data      N  writeback candidate when MemtoReg
//           PC_4           N  writeback candidate when JalLink
//           WriteRegister  5  destination register
//           MemtoReg       1  select Read_data
//           RegWrite       1  write enable
//           JalLink        1  select PC_4, outranks MemtoReg
//           ReadReg1/2     5  ID read addresses
//           ReadData1/2    N  ID read data
//           WB_data        N  selected writeback value (for forwarding)
//           RetireCount   32  committed register writes, wraps silently
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int           N       = 32,
  parameter logic [N-1:0] SP_INIT = DEFAULT_SP_INIT,
  parameter logic [N-1:0] GP_INIT = DEFAULT_GP_INIT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ALU_result,
  input  logic [N-1:0] Read_data,
  input  logic [N-1:0] PC_4,
  input  logic [4:0]   WriteRegister,
  input  logic         MemtoReg,
  input  logic         RegWrite,
  input  logic         JalLink,
  input  logic [4:0]   ReadReg1,
  input  logic [4:0]   ReadReg2,
  output logic [N-1:0] ReadData1,
  output logic [N-1:0] ReadData2,
  output logic [N-1:0] WB_data,
  output logic [31:0]  RetireCount
);

  logic [N-1:0] r_regs [0:31];
  logic [31:0]  r_retire_count;
  logic         w_commit;
  logic         w_byp1;
  logic         w_byp2;

  wb_mux #(.N(N)) u_wb_mux (
    .i_alu_result (ALU_result),
    .i_read_data  (Read_data),
    .i_pc_4       (PC_4),
    .i_jal_link   (JalLink),
    .i_mem_to_reg (MemtoReg),
    .o_wb_data    (WB_data)
  );

  // Writes to $zero are dropped and do not count as retired writes.
  assign w_commit = RegWrite && (WriteRegister != REG_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[REG_GP] <= GP_INIT;
      r_regs[REG_SP] <= SP_INIT;
      r_retire_count <= 32'd0;
    end else if (w_commit) begin
      r_regs[WriteRegister] <= WB_data;
      r_retire_count        <= r_retire_count + 32'd1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Same-cycle write-before-read; w_commit already excludes $zero.
  assign w_byp1 = w_commit && (ReadReg1 == WriteRegister);
  assign w_byp2 = w_commit && (ReadReg2 == WriteRegister);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign ReadData1 = (ReadReg1 == REG_ZERO) ? '0 :
                     w_byp1                 ? WB_data : r_regs[ReadReg1];
  assign ReadData2 = (ReadReg2 == REG_ZERO) ? '0 :
                     w_byp2                 ? WB_data : r_regs[ReadReg2];

  assign RetireCount = r_retire_count;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] ALU_result;
  logic [31:0] Read_data;
  logic [31:0] PC_4;
  logic [4:0]  WriteRegister;
  logic        MemtoReg;
  logic        RegWrite;
  logic        JalLink;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WB_data;
  logic [31:0] RetireCount;

  int errors = 0;
  int checks = 0;

  wb_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .ALU_result    (ALU_result),
    .Read_data     (Read_data),
    .PC_4          (PC_4),
    .WriteRegister (WriteRegister),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .JalLink       (JalLink),
    .ReadReg1      (ReadReg1),
    .ReadReg2      (ReadReg2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WB_data       (WB_data),
    .RetireCount   (RetireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MEM/WB drives on negedge; the following posedge commits.
  task automatic drive_wb(input logic [4:0] wr, input logic [31:0] alu,
                          input logic [31:0] rd, input logic [31:0] pc,
                          input logic mtr, input logic jal, input logic we);
    @(negedge clk);
    WriteRegister = wr;
    ALU_result    = alu;
    Read_data     = rd;
    PC_4          = pc;
    MemtoReg      = mtr;
    JalLink       = jal;
    RegWrite      = we;
  endtask

  task automatic commit_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_wb(5'd5, 32'h0000_0055, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    commit_edge();
    ReadReg1 = 5'd5;
    #1;
    checks++;
    if (ReadData1 !== 32'h0000_0055) begin
      errors++; $display("FAIL pre_reset_write r5 got=%h exp=%h", ReadData1, 32'h55);
    end
    #2;
    reset = 1'b0;
    ALU_result = '0; Read_data = '0; PC_4 = '0; WriteRegister = '0;
    MemtoReg = 1'b0; JalLink = 1'b0; RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 32'd0) begin
      errors++; $display("FAIL reset_clears_r5 got=%h exp=%h", ReadData1, 32'd0);
    end
    ReadReg1 = 5'd29; ReadReg2 = 5'd28;
    #1;
    checks++;
    if (ReadData1 !== 32'h7FFF_EFFC) begin
      errors++; $display("FAIL reset_sp got=%h exp=%h", ReadData1, 32'h7FFF_EFFC);
    end
    checks++;
    if (ReadData2 !== 32'h1000_8000) begin
      errors++; $display("FAIL reset_gp got=%h exp=%h", ReadData2, 32'h1000_8000);
    end
    checks++;
    if (RetireCount !== 32'd0) begin
      errors++; $display("FAIL reset_count got=%h exp=%h", RetireCount, 32'd0);
    end
    checks++;
    if (WB_data !== 32'd0) begin
      errors++; $display("FAIL reset_wb_data got=%h exp=%h", WB_data, 32'd0);
    end
    for (int r = 0; r < 32; r++) begin
      if (r != 28 && r != 29) begin
        ReadReg1 = 5'(r);
        #1;
        checks++;
        if (ReadData1 !== 32'd0) begin
          errors++; $display("FAIL reset_reg%0d got=%h exp=%h", r, ReadData1, 32'd0);
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_alu_write();
    drive_wb(5'd8, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
    ReadReg1 = 5'd8;
    #1;
    checks++;
    if (WB_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_wb_data got=%h exp=%h", WB_data, 32'hDEAD_BEEF);
    end
    commit_edge();
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_write_r8 got=%h exp=%h", ReadData1, 32'hDEAD_BEEF);
    end
    checks++;
    if (RetireCount !== 32'd1) begin
      errors++; $display("FAIL alu_count got=%h exp=%h", RetireCount, 32'd1);
    end
  endtask

  task automatic test_load_link();
    drive_wb(5'd9, 32'hAAAA_AAAA, 32'h0000_1234, 32'h3333_3333, 1'b1, 1'b0, 1'b1);
    ReadReg1 = 5'd9;
    #1;
    checks++;
    if (WB_data !== 32'h0000_1234) begin
      errors++; $display("FAIL load_wb_data got=%h exp=%h", WB_data, 32'h1234);
    end
    commit_edge();
    checks++;
    if (ReadData1 !== 32'h0000_1234) begin
      errors++; $display("FAIL load_r9 got=%h exp=%h", ReadData1, 32'h1234);
    end
    drive_wb(5'd31, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0040_0008, 1'b1, 1'b1, 1'b1);
    ReadReg2 = 5'd31;
    #1;
    checks++;
    if (WB_data !== 32'h0040_0008) begin
      errors++; $display("FAIL link_priority_wb_data got=%h exp=%h", WB_data, 32'h0040_0008);
    end
    commit_edge();
    checks++;
    if (ReadData2 !== 32'h0040_0008) begin
      errors++; $display("FAIL link_r31 got=%h exp=%h", ReadData2, 32'h0040_0008);
    end
    checks++;
    if (RetireCount !== 32'd3) begin
      errors++; $display("FAIL link_count got=%h exp=%h", RetireCount, 32'd3);
    end
  endtask

  task automatic test_zero_reg();
    drive_wb(5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    ReadReg1 = 5'd0;
    #1;
    checks++;
    if (ReadData1 !== 32'd0) begin
      errors++; $display("FAIL zero_no_bypass got=%h exp=%h", ReadData1, 32'd0);
    end
    commit_edge();
    checks++;
    if (ReadData1 !== 32'd0) begin
      errors++; $display("FAIL zero_after_write got=%h exp=%h", ReadData1, 32'd0);
    end
    checks++;
    if (RetireCount !== 32'd3) begin
      errors++; $display("FAIL zero_count got=%h exp=%h", RetireCount, 32'd3);
    end
  endtask

  task automatic test_hold();
    drive_wb(5'd8, 32'h0BAD_0BAD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    ReadReg1 = 5'd8;
    commit_edge();
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL hold_r8 got=%h exp=%h", ReadData1, 32'hDEAD_BEEF);
    end
    checks++;
    if (RetireCount !== 32'd3) begin
      errors++; $display("FAIL hold_count got=%h exp=%h", RetireCount, 32'd3);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_early;
    drive_wb(5'd10, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    commit_edge();
    drive_wb(5'd10, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    ReadReg1 = 5'd10;
    ReadReg2 = 5'd10;
`ifdef REGFILE_BYPASS_EN
    exp_early = 32'd7;
`else
    exp_early = 32'd5;
`endif
    #1;
    checks++;
    if (ReadData2 !== exp_early) begin
      errors++; $display("FAIL bypass_early_rd2 got=%h exp=%h", ReadData2, exp_early);
    end
    checks++;
    if (ReadData1 !== exp_early) begin
      errors++; $display("FAIL bypass_early_rd1 got=%h exp=%h", ReadData1, exp_early);
    end
    commit_edge();
    checks++;
    if (ReadData2 !== 32'd7) begin
      errors++; $display("FAIL bypass_after_commit got=%h exp=%h", ReadData2, 32'd7);
    end
    checks++;
    if (RetireCount !== 32'd5) begin
      errors++; $display("FAIL bypass_count got=%h exp=%h", RetireCount, 32'd5);
    end
  endtask

  task automatic test_same_port();
    drive_wb(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    ReadReg1 = 5'd8;
    ReadReg2 = 5'd8;
    #1;
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF || ReadData2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_addr rd1=%h rd2=%h exp=%h", ReadData1, ReadData2, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    dut.r_retire_count = 32'hFFFF_FFFF;
    drive_wb(5'd11, 32'h0000_00AB, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    commit_edge();
    checks++;
    if (RetireCount !== 32'd0) begin
      errors++; $display("FAIL wrap_count got=%h exp=%h", RetireCount, 32'd0);
    end
    drive_wb(5'd11, 32'h0000_00CD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    ReadReg1 = 5'd11;
    commit_edge();
    checks++;
    if (RetireCount !== 32'd0) begin
      errors++; $display("FAIL wrap_hold_count got=%h exp=%h", RetireCount, 32'd0);
    end
    checks++;
    if (ReadData1 !== 32'h0000_00AB) begin
      errors++; $display("FAIL wrap_r11 got=%h exp=%h", ReadData1, 32'hAB);
    end
  endtask

  initial begin
    reset = 1'b0;
    ALU_result = '0; Read_data = '0; PC_4 = '0; WriteRegister = '0;
    MemtoReg = 1'b0; JalLink = 1'b0; RegWrite = 1'b0;
    ReadReg1 = '0; ReadReg2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_alu_write();
    test_load_link();
    test_zero_reg();
    test_hold();
    test_bypass();
    test_same_port();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout sim_time=%0t limit=%0d", $time, 20000);
    $fatal(1);
  end

endmodule
